// File: rtl/mc_main_fsm.sv
// Main sequencing FSM for the multicycle MIPS core: steps each instruction
// through fetch/decode/execute/memory/writeback and decodes all datapath controls.
module mc_main_fsm #(
  parameter int unsigned STATE_W          = 4,
  parameter bit          ILLEGAL_TO_FETCH = 1'b1
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemToReg,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               PCEn,
  output logic               ExtOp,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic [2:0]         ALUCtl,
  output logic [STATE_W-1:0] Stat
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTYPE  = 4'd6,
    ALUWB  = 4'd7,
    BEQ    = 4'd8,
    IEXEC  = 4'd9,
    IWB    = 4'd10,
    JUMP   = 4'd11,
    BNE    = 4'd12,
    HALT   = 4'd15
  } state_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state, state_nxt;

  logic       rtype_ok;
  logic [2:0] rtype_alu;
  logic       imm_ext;
  logic [2:0] imm_alu;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    rtype_ok  = 1'b1;
    rtype_alu = ALU_ADD;
    unique case (Funct)
      6'h20:   rtype_alu = ALU_ADD;
      6'h22:   rtype_alu = ALU_SUB;
      6'h24:   rtype_alu = ALU_AND;
      6'h25:   rtype_alu = ALU_OR;
      6'h2A:   rtype_alu = ALU_SLT;
      default: rtype_ok  = 1'b0;
    endcase
  end

  always_comb begin
    imm_ext = 1'b1;
    imm_alu = ALU_ADD;
    unique case (Op)
      6'h0A:   imm_alu = ALU_SLT;
      6'h0C:   begin imm_ext = 1'b0; imm_alu = ALU_AND; end
      6'h0D:   begin imm_ext = 1'b0; imm_alu = ALU_OR;  end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = FETCH;
    IorD      = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 1'b0;
    MemToReg  = 1'b0;
    ALUSrcA   = 1'b0;
    RegWrite  = 1'b0;
    PCEn      = 1'b0;
    ExtOp     = 1'b1;
    ALUSrcB   = 2'b00;
    PCSrc     = 2'b00;
    ALUCtl    = ALU_AND;
    unique case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b01;
        ALUCtl    = ALU_ADD;
        PCEn      = 1'b1;
        state_nxt = DECODE;
      end
      DECODE: begin
        ALUSrcB   = 2'b11;
        ALUCtl    = ALU_ADD;
        state_nxt = ILLEGAL_TO_FETCH ? FETCH : HALT;
        unique case (Op)
          6'h23, 6'h2B:               state_nxt = MEMADR;
          6'h00:                      if (rtype_ok) state_nxt = RTYPE;
          6'h04:                      state_nxt = BEQ;
          6'h05:                      state_nxt = BNE;
          6'h08, 6'h0C, 6'h0D, 6'h0A: state_nxt = IEXEC;
          6'h02:                      state_nxt = JUMP;
          default: ;
        endcase
      end
      MEMADR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ALUCtl    = ALU_ADD;
        state_nxt = (Op == 6'h2B) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        IorD      = 1'b1;
        state_nxt = MEMWB;
      end
      MEMWB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      RTYPE: begin
        ALUSrcA   = 1'b1;
        ALUCtl    = rtype_alu;
        state_nxt = ALUWB;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BEQ, BNE: begin
        ALUSrcA = 1'b1;
        ALUCtl  = ALU_SUB;
        PCSrc   = 2'b01;
        PCEn    = (state == BEQ) ? Zero : ~Zero;
      end
      IEXEC: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ExtOp     = imm_ext;
        ALUCtl    = imm_alu;
        state_nxt = IWB;
      end
      IWB: begin
        RegWrite = 1'b1;
        ExtOp    = imm_ext;
        ALUCtl   = imm_alu;
      end
      JUMP: begin
        PCSrc = 2'b10;
        PCEn  = 1'b1;
      end
      HALT:    state_nxt = HALT;
      default: ;
    endcase
    // State resets asynchronously to FETCH, whose write strobes must stay off during reset.
    if (Reset) begin
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      PCEn     = 1'b0;
    end
  end

  assign Stat = STATE_W'(state);

endmodule
